ram_axi_master: RTL
===================

RAM_AXI_MASTER -- requirements
Module: ram_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: cycles to wait for a RAM handshake before an error response.
REQ-002 SHALL have ports clk  input  1  the single clock; rising edge active.
REQ-003 SHALL have ports rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid  input  1  CPU request valid.
REQ-005 SHALL have ports req_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports req_addr  input  64  byte address; misaligned addresses are allowed.
REQ-007 SHALL have ports req_wdata  input  64  write data.
REQ-008 SHALL have ports req_wmask  input  8  byte write enables; bit i covers byte i.
REQ-009 SHALL have ports req_ready  output  1  request accepted when req_valid is also high.
REQ-010 SHALL have ports resp_valid / resp_ready  output / input  1 each  response handshake.
REQ-011 SHALL have ports resp_rdata  output  64  read data; resp_err  output  1  error flag.
REQ-012 SHALL have ports ram_raddr_o  output  32  read address; ram_ren_o  output  1  read enable.
REQ-013 SHALL have ports ram_waddr_o  output  32  write address; ram_wen_o  output  1  write enable.
REQ-014 SHALL have ports ram_wdata_o  output  64  write data; ram_wmask_o  output  64  bit-granular write mask.
REQ-015 SHALL have ports ram_rdata_i  input  64  read data; ram_rready_i, ram_wready_i, ram_bvalid_i  input  1 each  RAM handshakes.

Function
REQ-016 SHALL implement the states IDLE, RD, WR, WAIT_B and RESP; only one transaction is outstanding at a time.
REQ-017 req_ready SHALL be 1 only in IDLE; on accept, addr, we, wdata and wmask SHALL be latched.
REQ-018 IDLE->RD (read) or IDLE->WR (write) SHALL occur on accept, except as REQ-019 states.
REQ-019 If req_addr[63:32] is nonzero on accept: go directly to RESP with resp_err=1 and resp_rdata=0, with no RAM access.
REQ-020 In RD: ram_ren_o=1 and ram_raddr_o=latched addr[31:0]; when ram_rready_i=1, capture ram_rdata_i into resp_rdata and go to RESP.
REQ-021 In WR: ram_wen_o=1 with waddr, wdata and wmask driven from the latched values; when ram_wready_i=1, go to WAIT_B.
REQ-022 ram_wen_o SHALL be high for exactly one cycle per write.
REQ-023 ram_wmask_o[8i+7:8i] SHALL equal {8{wmask[i]}}.
REQ-024 ram_wdata_o SHALL equal wdata AND ram_wmask_o, because the RAM ORs data into the masked-off old word.
REQ-025 In WAIT_B: when ram_bvalid_i=1, go to RESP with resp_err=0.
REQ-026 A counter SHALL clear on entry to RD, WR and WAIT_B and increment each cycle spent waiting.
REQ-027 When the counter reaches TIMEOUT-1 with no handshake: go to RESP with resp_err=1; resp_rdata SHALL be 0 on a read timeout.
REQ-028 In RESP: resp_valid=1, and resp_rdata and resp_err SHALL be held stable until resp_ready=1; then go to IDLE.
REQ-029 If resp_ready is held at 1, the next request SHALL be accepted one cycle later.
REQ-030 ram_ren_o and ram_wen_o SHALL never be high in the same cycle.
REQ-031 All RAM outputs SHALL be 0 outside RD and WR.
REQ-032 Latency with always-ready RAM: read accept at cycle 0 -> resp_valid at cycle 2.
REQ-033 Latency with always-ready RAM: write accept at cycle 0 -> wen at cycle 1 -> bvalid at cycle 2 -> resp_valid at cycle 3.
REQ-034 If req_valid is asserted outside IDLE, it SHALL be ignored (req_ready=0).

Reset
REQ-035 rst=1 SHALL immediately force IDLE and clear the counter and all latched request registers.
REQ-036 During reset, outputs SHALL be: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, and every ram_* output = 0.
REQ-037 req_ready SHALL become 1 on the first cycle after rst deasserts.
REQ-038 Reset asserted mid-transaction SHALL abort it with no response; a pending ram_wen_o SHALL drop the same cycle.

Verification
REQ-039 Read of addr 0x8 with RAM word = 0x1122334455667788 -> ram_raddr_o=0x8 for 1 cycle; resp_rdata=0x1122334455667788 two cycles after accept; resp_err=0.
REQ-040 Write addr 0x10, wdata=0xFFFFFFFFFFFFFFFF, wmask=0x0F -> ram_wmask_o=0x00000000FFFFFFFF and ram_wdata_o=0x00000000FFFFFFFF, wen for 1 cycle; resp_valid three cycles after accept.
REQ-041 Write with ram_bvalid_i tied to 0, TIMEOUT=16 -> resp_valid with resp_err=1 after 16 cycles in WAIT_B.
REQ-042 Read of addr 0x1_0000_0000 -> no ram_ren_o pulse; resp_valid=1 the next cycle with resp_err=1 and resp_rdata=0.
REQ-043 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable for all 5; req_ready=0 throughout.
REQ-044 rst pulsed during WR -> ram_wen_o=0 in the same cycle; no resp_valid; req_ready=1 the cycle after release.

Source files
------------

// File: rtl/ram_axi_master.sv
// ram_axi_master
// Bridges a single-outstanding CPU request/response port onto a simple
// RAM port with separate read and write channels. Each request is
// latched on accept, issued to the RAM, and answered with one response.
// RAM handshakes are guarded by a timeout that turns into an error response.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready : CPU request handshake; req_ready is high only in IDLE
//   req_we              : 1 = write, 0 = read
//   req_addr            : 64-bit byte address; only the low 32 bits reach the RAM
//   req_wdata/req_wmask : write data and per-byte enables
//   resp_valid/ready    : response handshake
//   resp_rdata/resp_err : read data (0 for writes and errors), error flag
//   ram_raddr_o/ren_o   : RAM read address and enable (active in RD only)
//   ram_waddr_o/wen_o   : RAM write address and enable (active in WR only)
//   ram_wdata_o/wmask_o : write data (pre-masked) and bit-granular mask
//   ram_rdata_i         : RAM read data
//   ram_rready_i        : read data valid
//   ram_wready_i        : write accepted
//   ram_bvalid_i        : write completion
module ram_axi_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_raddr_o,
    output logic        ram_ren_o,
    output logic [31:0] ram_waddr_o,
    output logic        ram_wen_o,
    output logic [63:0] ram_wdata_o,
    output logic [63:0] ram_wmask_o,
    input  logic [63:0] ram_rdata_i,
    input  logic        ram_rready_i,
    input  logic        ram_wready_i,
    input  logic        ram_bvalid_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, WR, WAIT_B, RESP} state_t;

    state_t        state, state_nxt;
    // Only the low half of the address is kept: a nonzero upper half is
    // rejected at accept time and never reaches the RAM. The read/write
    // direction is carried by the state itself.
    logic [31:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [7:0]    wmask_q;
    logic [CW-1:0] cnt;
    logic [63:0]   wmask_bits;

    logic accept;
    logic addr_err;
    logic timeout;
    logic waiting;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign addr_err  = |req_addr[63:32];
    assign timeout   = (cnt == CW'(TIMEOUT - 1));
    assign waiting   = (state == RD) || (state == WR) || (state == WAIT_B);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= state_nxt;
        end
    end

    // Next-state logic. A handshake always wins over a timeout in the same cycle.
    always_comb begin
        // NOTE: the default assignment up front keeps this block latch-free
        // for every path through the case statement.
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = addr_err ? RESP : (req_we ? WR : RD);
            RD:      if (ram_rready_i || timeout) state_nxt = RESP;
            WR:      if (ram_wready_i) state_nxt = WAIT_B;
                     else if (timeout) state_nxt = RESP;
            WAIT_B:  if (ram_bvalid_i || timeout) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is cleared by reset; there is no
            // storage array, so nothing is left holding stale request data.
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr[31:0];
                wdata_q    <= req_wdata;
                wmask_q    <= req_wmask;
                resp_rdata <= '0;
                resp_err   <= addr_err;
            end

            // Restart the count on every entry into a waiting state,
            // including the WR -> WAIT_B hop.
            if (state_nxt != state &&
                (state_nxt == RD || state_nxt == WR || state_nxt == WAIT_B)) begin
                cnt <= '0;
            end else if (waiting) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                RD: begin
                    if (ram_rready_i) resp_rdata <= ram_rdata_i;
                    else if (timeout) resp_err   <= 1'b1;
                end
                WR:      if (!ram_wready_i && timeout) resp_err <= 1'b1;
                WAIT_B:  if (!ram_bvalid_i && timeout) resp_err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Byte enables widened to a bit mask.
    always_comb begin
        wmask_bits = '0;
        for (int i = 0; i < 8; i++) begin
            wmask_bits[8*i +: 8] = {8{wmask_q[i]}};
        end
    end

    // RAM outputs are gated by state so they are zero everywhere except
    // RD/WR, and drop as soon as reset forces IDLE.
    assign ram_ren_o   = (state == RD);
    assign ram_raddr_o = ram_ren_o ? addr_q : '0;
    assign ram_wen_o   = (state == WR);
    assign ram_waddr_o = ram_wen_o ? addr_q : '0;
    assign ram_wmask_o = ram_wen_o ? wmask_bits : '0;
    // The RAM ORs data into the masked-off old word, so unmasked data bits
    // must be zero.
    assign ram_wdata_o = ram_wen_o ? (wdata_q & wmask_bits) : '0;

    assign resp_valid  = (state == RESP);

endmodule
